// File: rtl/vga_pkg.sv
// Shared VGA definitions: Bayer matrix, palette encoding, PMOD bit map and 640x480 timing.
// The TEMPORAL_DITHER_EN build option is consumed by vga_dither_stage.
package vga_pkg;

    typedef enum logic [1:0] {
        PAL_GREY = 2'd0,
        PAL_WARM = 2'd1,
        PAL_COOL = 2'd2,
        PAL_INV  = 2'd3
    } palette_e;

    // One 8-bit intensity per channel, indexed by CH_R/CH_G/CH_B.
    typedef logic [2:0][7:0] rgb_t;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // uo_out = {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}
    localparam int PMOD_HSYNC    = 7;
    localparam int PMOD_VSYNC    = 3;
    localparam int PMOD_LSB_BASE = 4;
    localparam int PMOD_MSB_BASE = 0;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] t;
        t = 4'd0;
        case ({row, col})
            4'b00_00: t = 4'd0;
            4'b00_01: t = 4'd8;
            4'b00_10: t = 4'd2;
            4'b00_11: t = 4'd10;
            4'b01_00: t = 4'd12;
            4'b01_01: t = 4'd4;
            4'b01_10: t = 4'd14;
            4'b01_11: t = 4'd6;
            4'b10_00: t = 4'd3;
            4'b10_01: t = 4'd11;
            4'b10_10: t = 4'd1;
            4'b10_11: t = 4'd9;
            4'b11_00: t = 4'd15;
            4'b11_01: t = 4'd7;
            4'b11_10: t = 4'd13;
            4'b11_11: t = 4'd5;
            default:  t = 4'd0;
        endcase
        return t;
    endfunction

    function automatic rgb_t palette_map(input palette_e pal, input logic [7:0] n);
        rgb_t c;
        c = '0;
        case (pal)
            PAL_GREY: begin
                c[CH_R] = n;
                c[CH_G] = n;
                c[CH_B] = n;
            end
            PAL_WARM: begin
                c[CH_R] = n;
                c[CH_G] = n >> 1;
                c[CH_B] = n >> 2;
            end
            PAL_COOL: begin
                c[CH_R] = n >> 2;
                c[CH_G] = n >> 1;
                c[CH_B] = n;
            end
            PAL_INV: begin
                c[CH_R] = ~n;
                c[CH_G] = ~n;
                c[CH_B] = ~n;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_bayer_quant.sv
// Reduces one 8-bit channel to 2 bits: the fractional nibble is compared with the
// Bayer threshold and rounds the coarse level up, saturating at 3.
module vga_bayer_quant (
    input  logic [7:0] intensity_i,
    input  logic [3:0] thresh_i,
    output logic [1:0] level_o
);

    logic [1:0] coarse;
    logic [3:0] frac;
    logic       unused_lsb;

    assign coarse     = intensity_i[7:6];
    assign frac       = intensity_i[5:2];
    assign unused_lsb = ^intensity_i[1:0];

    assign level_o = ((frac > thresh_i) && (coarse != 2'd3)) ? coarse + 2'd1 : coarse;

endmodule

// File: rtl/vga_dither_stage.sv
// Two-stage pixel back-end: palette lookup + Bayer threshold, then 2-bit quantise and PMOD pack.
// Define TEMPORAL_DITHER_EN to rotate the Bayer pattern over a 4-frame cycle.
module vga_dither_stage
    import vga_pkg::*;
#(
    parameter int NOISE_W = 8,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on_in,
    input  logic [9:0]         x_in,
    input  logic [9:0]         y_in,
    input  logic [NOISE_W-1:0] noise_in,
    input  logic [1:0]         palette_sel,
    output logic [7:0]         uo_out
);

    generate
        if (NOISE_W != 8) begin : g_bad_noise_w
            $error("vga_dither_stage supports only NOISE_W = 8");
        end
        if (LATENCY != 2) begin : g_bad_latency
            $error("vga_dither_stage has a fixed LATENCY of 2");
        end
    endgenerate

    palette_e   pal_q;
    logic       hsync_s1_q;
    logic       vsync_s1_q;
    logic       de_s1_q;
    rgb_t       rgb_s1_q;
    logic [3:0] thr_s1_q;
    logic [7:0] uo_q;

    rgb_t       rgb_d;
    logic [3:0] thr_d;
    logic [7:0] uo_d;
    logic       vsync_rise;
    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic       unused_pos;

    // Rising edge is judged against the vsync already held in stage 1.
    assign vsync_rise = vsync_in & ~vsync_s1_q;
    assign unused_pos = ^{x_in[9:2], y_in[9:2]};

`ifdef TEMPORAL_DITHER_EN
    logic [1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 2'd0;
        end else if (vsync_rise) begin
            frame_cnt_q <= frame_cnt_q + 2'd1;
        end
    end

    assign row_idx = y_in[1:0] + {frame_cnt_q[1], 1'b0};
    assign col_idx = x_in[1:0] + {frame_cnt_q[0], 1'b0};
`else
    assign row_idx = y_in[1:0];
    assign col_idx = x_in[1:0];
`endif

    assign rgb_d = palette_map(pal_q, noise_in[7:0]);
    assign thr_d = bayer(row_idx, col_idx);

    // Palette updates take effect for the capture after the one on the vsync edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_q      <= PAL_GREY;
            hsync_s1_q <= 1'b0;
            vsync_s1_q <= 1'b0;
            de_s1_q    <= 1'b0;
            rgb_s1_q   <= '0;
            thr_s1_q   <= 4'd0;
        end else begin
            if (vsync_rise) begin
                pal_q <= palette_e'(palette_sel);
            end
            hsync_s1_q <= hsync_in;
            vsync_s1_q <= vsync_in;
            de_s1_q    <= display_on_in;
            rgb_s1_q   <= rgb_d;
            thr_s1_q   <= thr_d;
        end
    end

    logic [2:0][1:0] level;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            vga_bayer_quant u_quant (
                .intensity_i (rgb_s1_q[gi]),
                .thresh_i    (thr_s1_q),
                .level_o     (level[gi])
            );
        end
    endgenerate

    always_comb begin
        uo_d             = 8'h00;
        uo_d[PMOD_HSYNC] = hsync_s1_q;
        uo_d[PMOD_VSYNC] = vsync_s1_q;
        for (int c = 0; c < 3; c++) begin
            uo_d[PMOD_LSB_BASE + c] = de_s1_q & level[c][0];
            uo_d[PMOD_MSB_BASE + c] = de_s1_q & level[c][1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_q <= 8'h00;
        end else begin
            uo_q <= uo_d;
        end
    end

    assign uo_out = uo_q;

endmodule
